// File: rtl/mod_inverse_if.sv
// Request/response bus of the mod_inverse engine: operands and start in, status and result out.
interface mod_inverse_if #(parameter int W = 32);
  logic         start;
  logic [W-1:0] value;
  logic [W-1:0] modulo;
  logic         busy;
  logic         finish;
  logic         valid;
  logic [W-1:0] result;

  modport master (output start, value, modulo, input busy, finish, valid, result);
  modport slave  (input start, value, modulo, output busy, finish, valid, result);
endinterface

// File: rtl/mod_inverse.sv
// Iterative extended-Euclid modular inverse using a bit-serial divider and double-and-add multiplier.
// Optional MODINV_VERIFY_EN adds a verify_ok output that checks value*result == 1 mod modulo.
module mod_inverse #(
  parameter int ARQ = 16
) (
  input  logic         clk,
  input  logic         reset,
  mod_inverse_if.slave bus
`ifdef MODINV_VERIFY_EN
  ,
  output logic         verify_ok
`endif
);

  localparam int W  = ARQ * 2;
  localparam int CW = $clog2(W);

  typedef enum logic [3:0] {
    IDLE, CHECK, DIV, MUL, UPDATE, DONE
`ifdef MODINV_VERIFY_EN
    , VDIV, VLOAD, VMUL
`endif
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  r0, r1, t0, t1, m;
  logic [W-1:0]  q, rem, acc;
  logic [CW-1:0] cnt;
  logic          degen;
  logic          valid_q;
  logic [W-1:0]  result_q;
`ifdef MODINV_VERIFY_EN
  logic [W-1:0]  op_value;
`endif

  // One restoring-division step: shift in the next dividend bit and try to subtract r1.
  logic [W:0]   div_sh;
  logic         div_ge;
  logic [W-1:0] div_diff;
  assign div_sh   = {rem, q[W-1]};
  assign div_ge   = div_sh >= {1'b0, r1};
  assign div_diff = div_sh[W-1:0] - r1;

  // One double-and-add step; both partial results stay below 2m, so W+1 bits suffice.
  logic [W:0]   dbl, sum;
  logic [W-1:0] dbl_red, acc_next;
  assign dbl      = {acc, 1'b0};
  assign dbl_red  = (dbl >= {1'b0, m}) ? dbl[W-1:0] - m : dbl[W-1:0];
  assign sum      = {1'b0, dbl_red} + (q[W-1] ? {1'b0, t1} : '0);
  assign acc_next = (sum >= {1'b0, m}) ? sum[W-1:0] - m : sum[W-1:0];

  logic last;
  assign last = (cnt == CW'(W - 1));

  always_comb begin
    // NOTE: default first, so no branch leaves state_n unassigned and no latch is inferred.
    state_n = state;
    case (state)
      IDLE, DONE: if (bus.start) state_n = CHECK;
      CHECK: begin
        if (degen) state_n = DONE;
        else if (r1 == '0) begin
`ifdef MODINV_VERIFY_EN
          state_n = (r0 == W'(1)) ? VDIV : DONE;
`else
          state_n = DONE;
`endif
        end else state_n = DIV;
      end
      DIV:    if (last) state_n = MUL;
      MUL:    if (last) state_n = UPDATE;
      UPDATE: state_n = CHECK;
`ifdef MODINV_VERIFY_EN
      VDIV:   if (last) state_n = VLOAD;
      VLOAD:  state_n = VMUL;
      VMUL:   if (last) state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      state    <= IDLE;
      r0       <= '0;
      r1       <= '0;
      t0       <= '0;
      t1       <= '0;
      m        <= '0;
      q        <= '0;
      rem      <= '0;
      acc      <= '0;
      cnt      <= '0;
      degen    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
`ifdef MODINV_VERIFY_EN
      op_value  <= '0;
      verify_ok <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            r0      <= bus.modulo;
            r1      <= bus.value;
            t0      <= '0;
            t1      <= W'(1);
            m       <= bus.modulo;
            degen   <= (bus.modulo < W'(2)) || (bus.value == '0);
            valid_q <= 1'b0;
`ifdef MODINV_VERIFY_EN
            op_value  <= bus.value;
            verify_ok <= 1'b0;
`endif
          end
        end
        CHECK: begin
          if (degen) begin
            valid_q  <= 1'b0;
            result_q <= '0;
          end else if (r1 == '0) begin
            valid_q  <= (r0 == W'(1));
            result_q <= (r0 == W'(1)) ? t0 : '0;
`ifdef MODINV_VERIFY_EN
            // Reuse the divider to reduce the original value by m.
            q   <= op_value;
            r1  <= m;
            rem <= '0;
            cnt <= '0;
`endif
          end else begin
            q   <= r0;
            rem <= '0;
            cnt <= '0;
          end
        end
`ifdef MODINV_VERIFY_EN
        DIV, VDIV: begin
`else
        DIV: begin
`endif
          q   <= {q[W-2:0], div_ge};
          rem <= div_ge ? div_diff : div_sh[W-1:0];
          cnt <= last ? '0 : cnt + 1'b1;
          acc <= '0;
        end
`ifdef MODINV_VERIFY_EN
        MUL, VMUL: begin
`else
        MUL: begin
`endif
          acc <= acc_next;
          q   <= {q[W-2:0], 1'b0};
          cnt <= last ? '0 : cnt + 1'b1;
`ifdef MODINV_VERIFY_EN
          if (state == VMUL && last) verify_ok <= (acc_next == W'(1));
`endif
        end
        UPDATE: begin
          r0 <= r1;
          r1 <= rem;
          t0 <= t1;
          t1 <= (t0 >= acc) ? t0 - acc : t0 + (m - acc);
        end
`ifdef MODINV_VERIFY_EN
        VLOAD: begin
          t1  <= rem;
          q   <= result_q;
          acc <= '0;
          cnt <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE) && (state != DONE);
  assign bus.finish = (state == DONE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mod_inverse.sv
// Directed-vector bench for mod_inverse; expected inverses and latencies are hand-computed.
module tb_mod_inverse;

  localparam int W     = 32;
  localparam int STEP  = 2 * W + 2;
  localparam int BOUND = 100 * STEP;
`ifdef MODINV_VERIFY_EN
  localparam int VLAT  = 2 * W + 1;
`else
  localparam int VLAT  = 0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  mod_inverse_if #(.W(W)) bif ();
`ifdef MODINV_VERIFY_EN
  logic verify_ok;
  mod_inverse #(.ARQ(16)) dut (.clk(clk), .reset(reset), .bus(bif), .verify_ok(verify_ok));
`else
  mod_inverse #(.ARQ(16)) dut (.clk(clk), .reset(reset), .bus(bif));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Start is sampled on the posedge between the two negedges; returns at the negedge after it.
  task automatic launch(input logic [W-1:0] v, input logic [W-1:0] md);
    @(negedge clk);
    bif.value  = v;
    bif.modulo = md;
    bif.start  = 1'b1;
    @(negedge clk);
    bif.start  = 1'b0;
  endtask

  // lat counts clock edges after the accepting edge until finish is seen high.
  task automatic wait_finish(input string tag, output int n);
    n = 0;
    while (!bif.finish && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish"}, W'(bif.finish), W'(1));
  endtask

  task automatic do_case(input string tag, input logic [W-1:0] v, input logic [W-1:0] md,
                         input logic exp_valid, input logic [W-1:0] exp_res, input int exp_lat);
    int n;
    launch(v, md);
    check({tag, "_busy"}, W'(bif.busy), W'(1));
    wait_finish(tag, n);
    check({tag, "_valid"}, W'(bif.valid), W'(exp_valid));
    check({tag, "_result"}, bif.result, exp_res);
    check({tag, "_busy_after"}, W'(bif.busy), W'(0));
    if (exp_lat >= 0) check({tag, "_latency"}, W'(n), W'(exp_lat + (exp_valid ? VLAT : 0)));
`ifdef MODINV_VERIFY_EN
    check({tag, "_verify_ok"}, W'(verify_ok), W'(exp_valid));
`endif
  endtask

  initial begin
    reset      = 1'b0;
    bif.start  = 1'b0;
    bif.value  = '0;
    bif.modulo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   W'(bif.busy),   W'(0));
    check("rst_finish", W'(bif.finish), W'(0));
    check("rst_valid",  W'(bif.valid),  W'(0));
    check("rst_result", bif.result,     W'(0));
    reset = 1'b1;

    // 8 Euclid steps for 1349/1840, 4 for 17/3120 and 10/7, 2 for 3/7 and 6/9.
    do_case("rsa_small", 1349, 1840, 1'b1, 1469, 8 * STEP + 1);
    do_case("rsa_17",    17,   3120, 1'b1, 2753, 4 * STEP + 1);
    do_case("restart",   3,    7,    1'b1, 5,    2 * STEP + 1);
    do_case("gcd3",      6,    9,    1'b0, 0,    2 * STEP + 1);
    do_case("mod1",      5,    1,    1'b0, 0,    1);
    do_case("val0",      0,    7,    1'b0, 0,    1);
    do_case("val_ge",    10,   7,    1'b1, 5,    4 * STEP + 1);

    // Start pulse and operand changes while busy must be ignored.
    launch(1349, 1840);
    repeat (20) @(negedge clk);
    bif.start  = 1'b1;
    bif.value  = 6;
    bif.modulo = 9;
    @(negedge clk);
    bif.start  = 1'b0;
    bif.value  = 0;
    bif.modulo = 0;
    check("abuse_busy", W'(bif.busy), W'(1));
    wait_finish("abuse", lat);
    check("abuse_valid",  W'(bif.valid), W'(1));
    check("abuse_result", bif.result,    W'(1469));

    // Reset in the middle of the first division pass aborts the run.
    launch(1349, 1840);
    repeat (5) @(negedge clk);
    check("mid_busy", W'(bif.busy), W'(1));
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",   W'(bif.busy),   W'(0));
    check("midrst_finish", W'(bif.finish), W'(0));
    check("midrst_valid",  W'(bif.valid),  W'(0));
    check("midrst_result", bif.result,     W'(0));
`ifdef MODINV_VERIFY_EN
    check("midrst_verify_ok", W'(verify_ok), W'(0));
`endif
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_finish", W'(bif.finish), W'(0));
    do_case("fresh", 1349, 1840, 1'b1, 1469, 8 * STEP + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
